// File: rtl/color_sched_pkg.sv
// Shared types and defaults for the color change scheduler.
// Imported by color_sched and its round-robin picker.
package color_sched_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_VBL = 1'b1
    } state_t;

    typedef logic [7:0] rgb332_t;

    localparam int unsigned NREQ_DEF          = 3;
    localparam rgb332_t     DEFAULT_COLOR_DEF = 8'hFF;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_rr_pick.sv
// Combinational round-robin picker: first requester with req high,
// searching upward from rr_ptr and wrapping modulo NREQ.
module color_rr_pick
    import color_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned PW  = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic            valid,
    output logic [PW-1:0]   index
);

    always_comb begin
        int unsigned j;
        j     = 0;
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = PW'(j);
            end
        end
    end

endmodule

// File: rtl/color_sched.sv
// Color change scheduler: grants one requester at a time and applies
// its latched color on the next vertical-sync falling edge.
module color_sched
    import color_sched_pkg::*;
#(
    parameter int unsigned NREQ          = NREQ_DEF,
    parameter int unsigned HOLD_FRAMES   = 2,
    parameter rgb332_t     DEFAULT_COLOR = DEFAULT_COLOR_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vs,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_color,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        color,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned PW = ptr_width(NREQ);
    localparam int unsigned HW = ptr_width(HOLD_FRAMES + 1);

    state_t          state_q, state_d;
    logic            vs_q;
    logic            frame_tick;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    rgb332_t         pending_q, pending_d;
    rgb332_t         color_d;
    logic [NREQ-1:0] ack_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;

    assign frame_tick = vs_q & ~vs;
    assign busy       = (state_q != IDLE) || (hold_q != '0);

    color_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            frame_cnt <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            pending_q <= DEFAULT_COLOR;
            color     <= DEFAULT_COLOR;
            ack       <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vs;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            color     <= color_d;
            ack       <= ack_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        pending_d = pending_q;
        color_d   = color;
        ack_d     = '0;
        hold_d    = hold_q;

        if (state_q == IDLE && frame_tick && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A tick in the grant cycle is not used; apply waits for the next one.
                if (hold_q == '0 && pick_valid) begin
                    grant_d   = pick_idx;
                    pending_d = req_color[32'(pick_idx)*8 +: 8];
                    state_d   = WAIT_VBL;
                end
            end
            WAIT_VBL: begin
                if (!req[grant_q]) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    color_d        = pending_q;
                    ack_d[grant_q] = 1'b1;
                    hold_d         = HW'(HOLD_FRAMES);
                    rr_ptr_d       = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_color_sched.sv
// Scoreboard bench for color_sched: expected acks are queued when requests
// are driven and popped when the DUT pulses ack.
module tb_color_sched;

    typedef struct {
        logic [2:0] ack;
        logic [7:0] color;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        vs;
    logic [2:0]  req,  req0;
    logic [23:0] req_color, req_color0;
    logic [2:0]  ack,  ack0;
    logic [7:0]  color, color0;
    logic        busy, busy0;
    logic [7:0]  frame_cnt, frame_cnt0;

    exp_t q[$];
    exp_t q0[$];
    int   checks   = 0;
    int   failures = 0;

    color_sched #(
        .NREQ          (3),
        .HOLD_FRAMES   (2),
        .DEFAULT_COLOR (8'hFF)
    ) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .vs        (vs),
        .req       (req),
        .req_color (req_color),
        .ack       (ack),
        .color     (color),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    color_sched #(
        .NREQ          (3),
        .HOLD_FRAMES   (0),
        .DEFAULT_COLOR (8'hFF)
    ) dut0 (
        .clk_sys   (clk),
        .reset     (reset),
        .vs        (vs),
        .req       (req0),
        .req_color (req_color0),
        .ack       (ack0),
        .color     (color0),
        .busy      (busy0),
        .frame_cnt (frame_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle low pulse on vs; returns at the negedge after the tick is registered.
    task automatic vs_fall();
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (ack !== 3'b000) begin
            if (q.size() == 0) begin
                check_eq("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = q.pop_front();
                check_eq("ack_idx", 32'(ack), 32'(e.ack));
                check_eq("ack_color", 32'(color), 32'(e.color));
            end
        end
    end

    always @(negedge clk) begin : mon_hold0
        exp_t e;
        if (ack0 !== 3'b000) begin
            if (q0.size() == 0) begin
                check_eq("ack0_unexpected", 32'(ack0), 32'd0);
            end else begin
                e = q0.pop_front();
                check_eq("ack0_idx", 32'(ack0), 32'(e.ack));
                check_eq("ack0_color", 32'(color0), 32'(e.color));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        vs         = 1'b1;
        req        = '0;
        req_color  = '0;
        req0       = '0;
        req_color0 = '0;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state and idle frames with vs held high
        check_eq("rst_color", 32'(color), 32'hFF);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        cycles(30);
        check_eq("vs_high_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("vs_high_color", 32'(color), 32'hFF);
        vs_fall();
        check_eq("first_tick_frame_cnt", 32'(frame_cnt), 32'd1);

        // Single request, then hold for two frames
        req[0]          = 1'b1;
        req_color[7:0]  = 8'hE0;
        q.push_back('{ack: 3'b001, color: 8'hE0});
        cycles(4);
        check_eq("wait_busy", 32'(busy), 32'd1);
        req_color[7:0]  = 8'h55;
        cycles(4);
        vs_fall();
        req[0] = 1'b0;
        check_eq("apply_color", 32'(color), 32'hE0);
        check_eq("apply_busy", 32'(busy), 32'd1);
        cycles(5);
        vs_fall();
        check_eq("hold1_busy", 32'(busy), 32'd1);
        cycles(5);
        vs_fall();
        check_eq("hold0_busy", 32'(busy), 32'd0);
        check_eq("hold_frame_cnt", 32'(frame_cnt), 32'd4);

        // Grant then abort before the tick
        req[1]           = 1'b1;
        req_color[15:8]  = 8'h1C;
        cycles(6);
        check_eq("abort_wait_busy", 32'(busy), 32'd1);
        req[1] = 1'b0;
        cycles(5);
        vs_fall();
        check_eq("abort_color", 32'(color), 32'hE0);
        check_eq("abort_busy", 32'(busy), 32'd0);

        // Grant cycle coincides with a tick: apply on the following tick
        @(negedge clk);
        req[2]           = 1'b1;
        req_color[23:16] = 8'h03;
        vs               = 1'b0;
        q.push_back('{ack: 3'b100, color: 8'h03});
        @(negedge clk);
        vs = 1'b1;
        check_eq("coincide_no_ack", 32'(ack), 32'd0);
        check_eq("coincide_color", 32'(color), 32'hE0);
        check_eq("coincide_busy", 32'(busy), 32'd1);
        cycles(5);
        vs_fall();
        req[2] = 1'b0;
        check_eq("coincide_apply_color", 32'(color), 32'h03);
        cycles(3);
        vs_fall();
        cycles(3);
        vs_fall();
        check_eq("coincide_hold_done", 32'(busy), 32'd0);

        // Reset while waiting with 0x1C pending
        req[1]          = 1'b1;
        req_color[15:8] = 8'h1C;
        cycles(5);
        check_eq("prerst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cycles(2);
        req[1] = 1'b0;
        check_eq("inrst_color", 32'(color), 32'hFF);
        reset = 1'b0;
        cycles(3);
        vs_fall();
        cycles(3);
        check_eq("postrst_color", 32'(color), 32'hFF);
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Round robin with all requesters high and no hold
        req_color0 = {8'hE0, 8'h1C, 8'h03};
        req0       = 3'b111;
        q0.push_back('{ack: 3'b001, color: 8'h03});
        q0.push_back('{ack: 3'b010, color: 8'h1C});
        q0.push_back('{ack: 3'b100, color: 8'hE0});
        q0.push_back('{ack: 3'b001, color: 8'h03});
        for (int f = 0; f < 4; f++) begin
            cycles(5);
            vs_fall();
        end
        req0 = '0;
        check_eq("rr_final_color", 32'(color0), 32'h03);

        // Drain, bounded
        for (int i = 0; i < 20 && (q.size() != 0 || q0.size() != 0); i++) begin
            @(negedge clk);
        end
        check_eq("sb_main_empty", 32'(q.size()), 32'd0);
        check_eq("sb_hold0_empty", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
